// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP/ACCESS sequence per AHB transfer.
// Optional macro AHB2APB_ERR_RESP_EN returns PSLVERR/timeouts as a two-cycle AHB ERROR.
module ahb2apb_bridge #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        ahb_hsel,
  input  logic [31:0] ahb_haddr,
  input  logic [1:0]  ahb_htrans,
  input  logic        ahb_hwrite,
  input  logic [1:0]  ahb_hsize,
  input  logic [31:0] ahb_hwdata,
  input  logic        ahb_hready,
  output logic        ahb_hreadyout,
  output logic [31:0] ahb_hrdata,
  output logic        ahb_hresp,
  input  logic [31:0] AHB_ADDR_MASK,
  input  logic [31:0] APB_ADDR_BASE,
  output logic        APBM_PSEL,
  output logic        APBM_PENABLE,
  output logic [31:0] APBM_PADDR,
  output logic        APBM_PWRITE,
  output logic [31:0] APBM_PWDATA,
  output logic [3:0]  APBM_PSTRB,
  input  logic [31:0] APBM_PRDATA,
  input  logic        APBM_PREADY,
  input  logic        APBM_PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e      state_q;
  logic        hreadyout_q, hresp_q;
  logic [31:0] hrdata_q;
  logic        psel_q, penable_q, pwrite_q;
  logic [31:0] paddr_q;
  logic [3:0]  pstrb_q;
  logic [31:0] tcnt_q;

  logic        capture;
  logic        timeout;
  logic        xfer_err;
  logic [3:0]  strb_d;
  logic        unused_htrans0;

  assign unused_htrans0 = ahb_htrans[0];

  assign capture = ahb_hsel & ahb_hready & ahb_htrans[1] &
                   ((state_q == S_IDLE) | (state_q == S_ERR2));

  assign timeout = (TIMEOUT != 0) && !APBM_PREADY && (tcnt_q == TIMEOUT - 1);

`ifdef AHB2APB_ERR_RESP_EN
  assign xfer_err = timeout | (APBM_PREADY & APBM_PSLVERR);
`else
  logic unused_pslverr;
  assign unused_pslverr = APBM_PSLVERR;
  assign xfer_err       = 1'b0;
`endif

  always_comb begin
    strb_d = '0;
    if (ahb_hwrite) begin
      case (ahb_hsize)
        2'd0:    strb_d = 4'b0001 << ahb_haddr[1:0];
        2'd1:    strb_d = ahb_haddr[1] ? 4'hC : 4'h3;
        default: strb_d = 4'hF;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pstrb_q     <= '0;
      tcnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR2: begin
          hresp_q <= 1'b0;
          if (capture) begin
            state_q     <= S_SETUP;
            hreadyout_q <= 1'b0;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            paddr_q     <= (ahb_haddr & AHB_ADDR_MASK) | APB_ADDR_BASE;
            pwrite_q    <= ahb_hwrite;
            pstrb_q     <= strb_d;
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
          tcnt_q    <= '0;
        end
        S_ACCESS: begin
          if (APBM_PREADY || timeout) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            // A timed-out read returns zero whether or not it is reported as an error.
            if (!pwrite_q && (timeout || !xfer_err))
              hrdata_q <= timeout ? '0 : APBM_PRDATA;
            if (xfer_err) begin
              state_q <= S_ERR1;
              hresp_q <= 1'b1;
            end else begin
              state_q     <= S_IDLE;
              hreadyout_q <= 1'b1;
            end
          end else begin
            tcnt_q <= tcnt_q + 32'd1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ahb_hreadyout = hreadyout_q;
  assign ahb_hrdata    = hrdata_q;
  assign ahb_hresp     = hresp_q;
  assign APBM_PSEL     = psel_q;
  assign APBM_PENABLE  = penable_q;
  assign APBM_PADDR    = paddr_q;
  assign APBM_PWRITE   = pwrite_q;
  assign APBM_PSTRB    = pstrb_q;
  // Write data is not registered: the AHB master holds HWDATA while hreadyout is low.
  assign APBM_PWDATA   = ((state_q == S_SETUP) || (state_q == S_ACCESS)) ? ahb_hwdata : '0;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Scoreboard bench for ahb2apb_bridge (TIMEOUT=4): expectations queued at issue, checked by monitors.
module tb_ahb2apb_bridge;

  localparam int unsigned TMO = 4;
`ifdef AHB2APB_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk, hresetn;
  logic        ahb_hsel, ahb_hwrite, ahb_hready, ahb_hreadyout, ahb_hresp;
  logic [31:0] ahb_haddr, ahb_hwdata, ahb_hrdata;
  logic [1:0]  ahb_htrans, ahb_hsize;
  logic [31:0] mask, base;
  logic        APBM_PSEL, APBM_PENABLE, APBM_PWRITE, APBM_PREADY, APBM_PSLVERR;
  logic [31:0] APBM_PADDR, APBM_PWDATA, APBM_PRDATA;
  logic [3:0]  APBM_PSTRB;

  assign ahb_hready = ahb_hreadyout;

  ahb2apb_bridge #(.TIMEOUT(TMO)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .ahb_hsel(ahb_hsel), .ahb_haddr(ahb_haddr), .ahb_htrans(ahb_htrans),
    .ahb_hwrite(ahb_hwrite), .ahb_hsize(ahb_hsize), .ahb_hwdata(ahb_hwdata),
    .ahb_hready(ahb_hready), .ahb_hreadyout(ahb_hreadyout), .ahb_hrdata(ahb_hrdata),
    .ahb_hresp(ahb_hresp), .AHB_ADDR_MASK(mask), .APB_ADDR_BASE(base),
    .APBM_PSEL(APBM_PSEL), .APBM_PENABLE(APBM_PENABLE), .APBM_PADDR(APBM_PADDR),
    .APBM_PWRITE(APBM_PWRITE), .APBM_PWDATA(APBM_PWDATA), .APBM_PSTRB(APBM_PSTRB),
    .APBM_PRDATA(APBM_PRDATA), .APBM_PREADY(APBM_PREADY), .APBM_PSLVERR(APBM_PSLVERR)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        write;
    logic        slverr;
    logic [1:0]  size;
    int unsigned waits;
  } txn_t;

  typedef struct {
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pwrite;
  } apb_exp_t;

  typedef struct {
    logic [31:0] hrdata;
    logic        hresp;
    bit          chk_rd;
    int unsigned low;
  } ahb_exp_t;

  apb_exp_t apb_q[$];
  ahb_exp_t ahb_q[$];
  txn_t     slv_q[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          mon_en = 1'b0;
  bit          busy = 1'b0;
  int unsigned lowc = 0;
  logic [31:0] last_rd = '0;
  bit          rd_known = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_strb(input txn_t t);
    int unsigned nb, lane, s;
    if (!t.write) return 4'h0;
    nb   = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
    lane = (int'(t.addr[1:0]) / nb) * nb;
    s    = ((1 << nb) - 1) << lane;
    return s[3:0];
  endfunction

  function automatic txn_t mk(input logic [31:0] addr, input logic write, input logic [1:0] size,
                              input logic [31:0] wdata, input int unsigned waits,
                              input logic slverr, input logic [31:0] prdata);
    txn_t t;
    t.addr = addr; t.write = write; t.size = size; t.wdata = wdata;
    t.waits = waits; t.slverr = slverr; t.prdata = prdata;
    return t;
  endfunction

  // APB slave: per-transfer wait states, data and error taken from slv_q.
  txn_t        cur;
  int unsigned wleft = 0;
  always @(negedge hclk) begin
    if (APBM_PSEL && !APBM_PENABLE) begin
      if (slv_q.size() != 0) cur = slv_q.pop_front();
      else cur = mk('0, 1'b0, 2'd2, '0, 0, 1'b0, '0);
      wleft        = cur.waits;
      APBM_PREADY  = 1'($urandom_range(0, 1));
      APBM_PRDATA  = $urandom;
      APBM_PSLVERR = 1'($urandom_range(0, 1));
    end else if (APBM_PSEL && APBM_PENABLE && wleft == 0) begin
      APBM_PREADY  = 1'b1;
      APBM_PRDATA  = cur.prdata;
      APBM_PSLVERR = cur.slverr;
    end else begin
      if (APBM_PSEL && APBM_PENABLE) wleft--;
      APBM_PREADY  = (APBM_PSEL && APBM_PENABLE) ? 1'b0 : 1'($urandom_range(0, 1));
      APBM_PRDATA  = $urandom;
      APBM_PSLVERR = 1'($urandom_range(0, 1));
    end
  end

  // Monitors: APB setup phase and AHB response.
  always @(negedge hclk) begin
    if (!mon_en || !hresetn) begin
      busy = 1'b0;
    end else begin
      if (APBM_PSEL && !APBM_PENABLE) begin
        if (apb_q.size() == 0) begin
          check("apb_unexpected_setup", 32'(APBM_PSEL), 32'd0);
        end else begin
          apb_exp_t a;
          a = apb_q.pop_front();
          check("paddr", APBM_PADDR, a.paddr);
          check("pwrite", 32'(APBM_PWRITE), 32'(a.pwrite));
          check("pstrb", 32'(APBM_PSTRB), 32'(a.pstrb));
          check("pwdata", APBM_PWDATA, a.pwdata);
        end
      end
      if (!ahb_hreadyout) begin
        if (!busy) begin busy = 1'b1; lowc = 0; end
        lowc++;
      end else if (busy) begin
        busy = 1'b0;
        if (ahb_q.size() == 0) begin
          check("ahb_unexpected_resp", 32'(busy), 32'd1);
        end else begin
          ahb_exp_t h;
          h = ahb_q.pop_front();
          check("wait_cycles", lowc, h.low);
          check("hresp", 32'(ahb_hresp), 32'(h.hresp));
          if (h.chk_rd) check("hrdata", ahb_hrdata, h.hrdata);
        end
      end else begin
        check("idle_hresp", 32'(ahb_hresp), 32'd0);
      end
    end
  end

  task automatic wait_ready();
    int unsigned n = 0;
    @(negedge hclk);
    while (!ahb_hreadyout && n < 64) begin
      @(negedge hclk);
      n++;
    end
    if (!ahb_hreadyout) begin
      n_err++;
      $display("FAIL ready_wait: hreadyout stuck at %b, expected 1", ahb_hreadyout);
    end
  endtask

  // Called at a negedge where hreadyout is high; returns at the completing negedge.
  task automatic issue(input txn_t t);
    apb_exp_t a;
    ahb_exp_t h;
    bit tmo, err;
    tmo = (t.waits >= TMO);
    err = ERR_EN && (tmo || t.slverr);
    a.paddr  = (t.addr & mask) | base;
    a.pwrite = t.write;
    a.pstrb  = exp_strb(t);
    a.pwdata = t.wdata;
    h.hresp  = err;
    h.low    = 1 + (tmo ? TMO : t.waits + 1) + (err ? 1 : 0);
    if (!t.write) begin
      if (tmo) begin last_rd = '0; rd_known = 1'b1; end
      else if (!err) begin last_rd = t.prdata; rd_known = 1'b1; end
      else rd_known = 1'b0;
    end
    h.chk_rd = rd_known && !err;
    h.hrdata = last_rd;
    apb_q.push_back(a);
    ahb_q.push_back(h);
    slv_q.push_back(t);
    ahb_hsel   = 1'b1;
    ahb_htrans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
    ahb_haddr  = t.addr;
    ahb_hwrite = t.write;
    ahb_hsize  = t.size;
    @(posedge hclk);
    #1;
    ahb_hwdata = t.wdata;
    ahb_hsel   = 1'($urandom_range(0, 1));
    ahb_htrans = 2'($urandom_range(0, 1));
    ahb_haddr  = $urandom;
    ahb_hwrite = 1'($urandom_range(0, 1));
    wait_ready();
  endtask

  task automatic idle_cycle();
    if ($urandom_range(0, 1) != 0) begin
      ahb_hsel = 1'b0; ahb_htrans = 2'($urandom_range(0, 3));
    end else begin
      ahb_hsel = 1'b1; ahb_htrans = 2'($urandom_range(0, 1));
    end
    ahb_haddr  = $urandom;
    ahb_hwrite = 1'($urandom_range(0, 1));
    @(negedge hclk);
  endtask

  txn_t dir[$];
  int unsigned wt;

  initial begin
    hresetn = 1'b0;
    ahb_hsel = 1'b0; ahb_htrans = 2'b00; ahb_haddr = '0; ahb_hwrite = 1'b0;
    ahb_hsize = 2'd2; ahb_hwdata = '0;
    mask = 32'h0000_FFFF; base = 32'h8000_0000;
    APBM_PREADY = 1'b0; APBM_PRDATA = '0; APBM_PSLVERR = 1'b0;
    #12;
    check("rst_hreadyout", 32'(ahb_hreadyout), 32'd1);
    check("rst_hrdata", ahb_hrdata, 32'd0);
    check("rst_hresp", 32'(ahb_hresp), 32'd0);
    check("rst_psel", 32'(APBM_PSEL), 32'd0);
    check("rst_penable", 32'(APBM_PENABLE), 32'd0);
    check("rst_pwrite", 32'(APBM_PWRITE), 32'd0);
    check("rst_paddr", APBM_PADDR, 32'd0);
    check("rst_pstrb", 32'(APBM_PSTRB), 32'd0);
    check("rst_pwdata", APBM_PWDATA, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    mon_en = 1'b1;

    dir.push_back(mk(32'h4000_0010, 1'b1, 2'd2, 32'h1234_5678, 0, 1'b0, 32'h0));
    dir.push_back(mk(32'h4000_0003, 1'b1, 2'd0, 32'h0000_00AB, 0, 1'b0, 32'h0));
    dir.push_back(mk(32'h4000_0002, 1'b1, 2'd1, 32'h0000_BEEF, 1, 1'b0, 32'h0));
    dir.push_back(mk(32'h4000_0008, 1'b0, 2'd2, 32'h5555_AAAA, 0, 1'b0, 32'h1111_2222));
    dir.push_back(mk(32'h4000_0020, 1'b0, 2'd2, 32'h0, 3, 1'b0, 32'hCAFE_F00D));
    dir.push_back(mk(32'h4000_0024, 1'b1, 2'd2, 32'hDEAD_0001, 0, 1'b1, 32'h0));
    dir.push_back(mk(32'h4000_0028, 1'b0, 2'd2, 32'h0, 1, 1'b1, 32'h7777_8888));
    dir.push_back(mk(32'h4000_002C, 1'b0, 2'd2, 32'h0, 100, 1'b0, 32'h9999_9999));
    dir.push_back(mk(32'h4000_0030, 1'b1, 2'd3, 32'h0BAD_F00D, 100, 1'b0, 32'h0));
    dir.push_back(mk(32'h4000_0034, 1'b0, 2'd2, 32'h0, 0, 1'b0, 32'h3141_5926));
    foreach (dir[i]) issue(dir[i]);

    // Asynchronous reset in the middle of an ACCESS phase.
    mon_en = 1'b0;
    slv_q.push_back(mk(32'h4000_0040, 1'b0, 2'd2, 32'h0, 100, 1'b0, 32'h0));
    ahb_hsel = 1'b1; ahb_htrans = 2'b10; ahb_haddr = 32'h4000_0040; ahb_hwrite = 1'b0;
    @(posedge hclk);
    #1;
    ahb_htrans = 2'b00;
    @(posedge hclk);
    #2;
    check("pre_rst_penable", 32'(APBM_PENABLE), 32'd1);
    hresetn = 1'b0;
    #1;
    check("arst_psel", 32'(APBM_PSEL), 32'd0);
    check("arst_penable", 32'(APBM_PENABLE), 32'd0);
    check("arst_hreadyout", 32'(ahb_hreadyout), 32'd1);
    check("arst_hrdata", ahb_hrdata, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    slv_q.delete(); apb_q.delete(); ahb_q.delete();
    last_rd = '0; rd_known = 1'b1;
    @(negedge hclk);
    mon_en = 1'b1;
    issue(mk(32'h4000_0044, 1'b0, 2'd2, 32'h0, 0, 1'b0, 32'h2468_ACE0));

    for (int unsigned i = 0; i < 250; i++) begin
      txn_t t;
      if (i == 125) begin
        mask = $urandom;
        base = $urandom;
      end
      wt = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      t = mk($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
             wt, ($urandom_range(0, 4) == 0), $urandom);
      issue(t);
      for (int unsigned k = $urandom_range(0, 3); k > 1; k--) idle_cycle();
    end

    for (int unsigned n = 0; n < 200 && (ahb_q.size() != 0 || busy); n++) @(negedge hclk);
    check("ahb_q_drained", ahb_q.size(), 32'd0);
    check("apb_q_drained", apb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
